// File: rtl/riscy_dmem_responder.sv
// Behavioural data-memory slave for the RISCY data port: fixed-latency in-order
// responses, bounded outstanding requests, preload backdoor. Optional DMEM_GNT_STALL_EN.
module riscy_dmem_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  input  logic                  pl_we_i,
  input  logic [ADDR_WIDTH-1:0] pl_addr_i,
  input  logic [31:0]           pl_wdata_i
);

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]               mem [2**ADDR_WIDTH];
  logic [LATENCY-1:0]        vld_pipe;
  logic [LATENCY-1:0][31:0]  dat_pipe;
  logic [CNT_W-1:0]          outstanding;
  logic [ADDR_WIDTH-1:0]     word;
  logic                      accept;
  logic                      stall;
  logic                      unused_addr;

  assign word        = data_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr = ^{data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0]};

`ifdef DMEM_GNT_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; a set LSB vetoes the grant that cycle
  logic [15:0] lfsr;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign data_gnt_o = data_req_i && (outstanding < MAX_CNT) && !stall;
  assign accept     = data_gnt_o;

  // Preload is issued after the store so it overrides every byte on a collision
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i) begin
      for (int b = 0; b < 4; b++)
        if (data_be_i[b]) mem[word][8*b +: 8] <= data_wdata_i[8*b +: 8];
    end
    if (pl_we_i) mem[pl_addr_i] <= pl_wdata_i;
  end

  // Stage data is zero unless it carries a load, so rdata is 0 whenever rvalid is 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      dat_pipe[0] <= (accept && !data_we_i) ? mem[word] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign data_rvalid_o = vld_pipe[LATENCY-1];
  assign data_rdata_o  = dat_pipe[LATENCY-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({accept, data_rvalid_o})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_riscy_dmem_responder.sv
// Bench for riscy_dmem_responder: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model of the memory and responses.
module tb_riscy_dmem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int MAX = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          data_req_i;
  logic          data_gnt_o;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i;
  logic [31:0]   data_wdata_i;
  logic          data_rvalid_o;
  logic [31:0]   data_rdata_o;
  logic          pl_we_i;
  logic [AW-1:0] pl_addr_i;
  logic [31:0]   pl_wdata_i;

  riscy_dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .pl_we_i(pl_we_i), .pl_addr_i(pl_addr_i), .pl_wdata_i(pl_wdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int due; logic [31:0] data; } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem_m [2**AW];
  logic [15:0] lfsr_m = 16'hACE1;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        acc_flag;
  int          acc_cyc;
  int          last_rv_cyc;
  int          rv_cnt;
  logic [31:0] last_rdata;
  logic [7:0]  gnt_hist;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then apply the accept/preload rules at the edge.
  task automatic cycle();
    logic        acc, stall, e_gnt, e_vld;
    logic [31:0] e_dat, cur;
    int          w;
    if (rst_i) begin
      q.delete();
      lfsr_m = 16'hACE1;
    end
    @(negedge clk_i);
`ifdef DMEM_GNT_STALL_EN
    stall = lfsr_m[0];
`else
    stall = 1'b0;
`endif
    e_gnt = data_req_i && (q.size() < MAX) && !stall;
    e_vld = (q.size() > 0) && (q[0].due == cyc);
    e_dat = e_vld ? q[0].data : 32'h0;
    chk("gnt", {31'b0, data_gnt_o}, {31'b0, e_gnt});
    chk("rvalid", {31'b0, data_rvalid_o}, {31'b0, e_vld});
    chk("rdata", data_rdata_o, e_dat);
    if (data_rvalid_o) begin
      last_rdata  = data_rdata_o;
      last_rv_cyc = cyc;
      rv_cnt++;
    end
    gnt_hist = {gnt_hist[6:0], data_gnt_o};
    acc = e_gnt && !rst_i;
    acc_flag = acc;
    if (acc) acc_cyc = cyc;
    @(posedge clk_i);
    w = int'(data_addr_i[AW+1:2]);
    if (acc) begin
      cur = mem_m[w];
      if (data_we_i) begin
        for (int b = 0; b < 4; b++)
          if (data_be_i[b]) cur[8*b +: 8] = data_wdata_i[8*b +: 8];
        mem_m[w] = cur;
        q.push_back('{due: cyc + LAT, data: 32'h0});
      end else begin
        q.push_back('{due: cyc + LAT, data: cur});
      end
    end
    if (pl_we_i) mem_m[pl_addr_i] = pl_wdata_i;
    if (!rst_i) lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    cyc++;
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    #1;
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pl_we_i = 1'b1; pl_addr_i = AW'(a); pl_wdata_i = d;
    cycle();
    pl_we_i = 1'b0;
  endtask

  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] d);
    int n = 0;
    data_req_i = 1'b1; data_we_i = we; data_be_i = be; data_addr_i = a; data_wdata_i = d;
    acc_flag = 1'b0;
    while (!acc_flag && n < 50) begin
      cycle();
      n++;
    end
    chk("gnt_wait", {31'b0, acc_flag}, 32'd1);
    data_req_i = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 3) cycle();
  endtask

  initial begin
    int n, k;
    logic [31:0] a;
    rst_i = 1'b1; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
    data_addr_i = '0; data_wdata_i = '0; pl_we_i = 1'b0; pl_addr_i = '0; pl_wdata_i = '0;
    gnt_hist = '0; rv_cnt = 0; last_rdata = '0; acc_cyc = 0; last_rv_cyc = 0;
    repeat (3) cycle();
    rst_i = 1'b0;

    // fill the whole array so no load ever observes an unwritten word
    for (int i = 0; i < 2**AW; i++) preload(i, $urandom);

    // preload then load: data and latency
    preload(4, 32'hDEADBEEF);
    last_rdata = 32'hBAD0BAD0;
    access(1'b0, 4'hF, 32'h10, 32'h0);
    k = acc_cyc;
    drain();
    chk("pl_load", last_rdata, 32'hDEADBEEF);
    chk("latency", 32'(last_rv_cyc - k), 32'(LAT));

    // byte-enable store, its zero response, then read-back
    preload(1, 32'h11223344);
    last_rdata = 32'hBAD0BAD0;
    access(1'b1, 4'b0101, 32'h4, 32'hAABBCCDD);
    drain();
    chk("st_rsp", last_rdata, 32'h0);
    access(1'b0, 4'hF, 32'h4, 32'h0);
    drain();
    chk("be_store", last_rdata, 32'h11BB33DD);

    // be=0 store leaves the word untouched
    access(1'b1, 4'b0000, 32'h4, 32'h0);
    access(1'b0, 4'hF, 32'h4, 32'h0);
    drain();
    chk("be_zero", last_rdata, 32'h11BB33DD);

    // preload collides with a store on the same edge
    pl_we_i = 1'b1; pl_addr_i = AW'(2); pl_wdata_i = 32'h0;
    access(1'b1, 4'hF, 32'h8, 32'hFFFFFFFF);
    pl_we_i = 1'b0;
    access(1'b0, 4'hF, 32'h8, 32'h0);
    drain();
    chk("collide", last_rdata, 32'h0);

    // req held for four loads: occupancy throttles the grant
    for (int i = 0; i < 4; i++) preload(20 + i, 32'hC0DE0000 + 32'(i));
    gnt_hist = '0; n = 0; k = 0;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
    while (k < 4 && n < 40) begin
      data_addr_i = 32'(20 + k) << 2;
      cycle();
      if (acc_flag) k++;
      n++;
    end
    data_req_i = 1'b0;
    chk("bp_loads", 32'(k), 32'd4);
`ifndef DMEM_GNT_STALL_EN
    chk("bp_cycles", 32'(n), 32'd5);
    chk("bp_gnt", {27'b0, gnt_hist[4:0]}, {27'b0, 5'b11011});
`endif
    drain();
    chk("bp_last", last_rdata, 32'hC0DE0003);

    // reset while a load is in flight: its response must never appear
    access(1'b0, 4'hF, 32'h10, 32'h0);
    rst_i = 1'b1;
    rv_cnt = 0;
    repeat (3) cycle();
    rst_i = 1'b0;
    repeat (LAT + 2) cycle();
    chk("rst_stale", 32'(rv_cnt), 32'd0);

    // random traffic over a small window so stores, loads and preloads collide
    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      a[11:6] = '0;
      data_req_i   = ($urandom_range(0, 3) != 0);
      data_we_i    = 1'($urandom_range(0, 1));
      data_be_i    = 4'($urandom);
      data_addr_i  = a;
      data_wdata_i = $urandom;
      pl_we_i      = ($urandom_range(0, 7) == 0);
      pl_addr_i    = AW'($urandom_range(0, 15));
      pl_wdata_i   = $urandom;
      cycle();
    end
    data_req_i = 1'b0; pl_we_i = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
